// File: rtl/backprop_pkg.sv
// Shared types, constants and fixed-point narrowing for the backprop engine.
// Build option: BP_SATURATE_EN selects clamping narrowing (default: two's-complement wrap).
package backprop_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_FRAC  = 12;
  localparam int unsigned DEF_N     = 4;
  localparam int          ONE       = 1 << DEF_FRAC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIG,
    S_DELTA,
    S_RATE,
    S_LOOP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } narrow_t;

  // Reduce a wide signed value to w bits; the caller keeps val[w-1:0].
  function automatic narrow_t narrow(input logic signed [63:0] x, input int unsigned w);
    narrow_t r;
`ifdef BP_SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (w - 1));
    r.sat = 1'b0;
    r.val = x;
    if (x > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (x < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
`else
    int unsigned sh;
    sh    = 64 - w;
    r.sat = 1'b0;
    r.val = (x <<< sh) >>> sh;
`endif
    return r;
  endfunction

endpackage

// File: rtl/backprop_engine_fxp_mul.sv
// Combinational signed fixed-point multiply: full product, floor shift by FRAC, narrow to WIDTH.
module fxp_mul
  import backprop_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p,
  output logic                    sat
);

  logic signed [2*WIDTH-1:0] prod;
  narrow_t                   n;
  logic                      unused_hi;

  assign prod      = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  assign n         = narrow(64'(prod >>> FRAC), WIDTH);
  assign p         = n.val[WIDTH-1:0];
  assign sat       = n.sat;
  assign unused_hi = ^n.val[63:WIDTH];

endmodule

// File: rtl/backprop_engine.sv
// Sequential single-neuron backprop: delta, per-input back error and weight update.
// Build option: BP_SATURATE_EN enables clamping narrowing and the sat_flag output.
module backprop_engine
  import backprop_pkg::*;
#(
  parameter int unsigned N_INPUTS = DEF_N,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned FRAC     = DEF_FRAC
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic signed [WIDTH-1:0]            axon,
  input  logic signed [WIDTH-1:0]            err_in,
  input  logic signed [WIDTH-1:0]            ratio,
  input  logic [N_INPUTS-1:0][WIDTH-1:0]     prev,
  input  logic [N_INPUTS-1:0][WIDTH-1:0]     weight,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N_INPUTS-1:0][WIDTH-1:0]     err_out,
  output logic [N_INPUTS-1:0][WIDTH-1:0]     weight_out,
  output logic                               busy
`ifdef BP_SATURATE_EN
  ,
  output logic                               sat_flag
`endif
);

  localparam int unsigned            IDXW  = $clog2(N_INPUTS) + 1;
  localparam logic [IDXW-1:0]        LAST  = IDXW'(N_INPUTS - 1);
  localparam logic signed [WIDTH:0]  ONE_X = (WIDTH+1)'(1 << FRAC);

  state_t                           state;
  logic [IDXW-1:0]                  idx;
  logic signed [WIDTH-1:0]          a_q, err_q, ratio_q;
  logic signed [WIDTH-1:0]          sig_q, delta_q, dr_q;
  logic [N_INPUTS-1:0][WIDTH-1:0]   prev_q, w_q;
  logic [N_INPUTS-1:0][WIDTH-1:0]   eo_q, wo_q, eo_next, wo_next;

  logic signed [WIDTH-1:0]          w_sel, p_sel;
  logic signed [WIDTH-1:0]          m0_a, m0_b, m0_p, m1_p;
  logic                             m0_sat, m1_sat;
  logic signed [WIDTH:0]            one_m_a, add_sum;
  narrow_t                          n_one, n_add;
  logic                             unused_hi;

  // Current-lane operand select, written as a compare loop so any index width is safe.
  always_comb begin
    w_sel = '0;
    p_sel = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (idx == IDXW'(k)) begin
        w_sel = w_q[k];
        p_sel = prev_q[k];
      end
    end
  end

  assign one_m_a   = ONE_X - {a_q[WIDTH-1], a_q};
  assign n_one     = narrow(64'(one_m_a), WIDTH);
  assign add_sum   = {w_sel[WIDTH-1], w_sel} + {m1_p[WIDTH-1], m1_p};
  assign n_add     = narrow(64'(add_sum), WIDTH);
  assign unused_hi = ^{n_one.val[63:WIDTH], n_add.val[63:WIDTH]};

  // The shared multiplier's operands follow the pipeline phase.
  always_comb begin
    m0_a = delta_q;
    m0_b = w_sel;
    case (state)
      S_SIG: begin
        m0_a = n_one.val[WIDTH-1:0];
        m0_b = a_q;
      end
      S_DELTA: begin
        m0_a = sig_q;
        m0_b = err_q;
      end
      S_RATE: begin
        m0_a = delta_q;
        m0_b = ratio_q;
      end
      default: ;
    endcase
  end

  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_shared (
    .a   (m0_a),
    .b   (m0_b),
    .p   (m0_p),
    .sat (m0_sat)
  );

  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_prev (
    .a   (dr_q),
    .b   (p_sel),
    .p   (m1_p),
    .sat (m1_sat)
  );

  // Results accumulate in shadow buffers so the visible outputs only change on completion.
  always_comb begin
    eo_next = eo_q;
    wo_next = wo_q;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (idx == IDXW'(k)) begin
        eo_next[k] = m0_p;
        wo_next[k] = n_add.val[WIDTH-1:0];
      end
    end
  end

`ifdef BP_SATURATE_EN
  logic sat_acc;
  logic loop_sat;
  assign loop_sat = m0_sat | m1_sat | n_add.sat;
`else
  logic unused_sat;
  assign unused_sat = m0_sat | m1_sat | n_one.sat | n_add.sat;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      a_q        <= '0;
      err_q      <= '0;
      ratio_q    <= '0;
      prev_q     <= '0;
      w_q        <= '0;
      sig_q      <= '0;
      delta_q    <= '0;
      dr_q       <= '0;
      eo_q       <= '0;
      wo_q       <= '0;
      err_out    <= '0;
      weight_out <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
`ifdef BP_SATURATE_EN
      sat_acc    <= 1'b0;
      sat_flag   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= axon;
            err_q    <= err_in;
            ratio_q  <= ratio;
            prev_q   <= prev;
            w_q      <= weight;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_SIG;
`ifdef BP_SATURATE_EN
            sat_acc  <= 1'b0;
            sat_flag <= 1'b0;
`endif
          end
        end
        S_SIG: begin
          sig_q <= m0_p;
          state <= S_DELTA;
`ifdef BP_SATURATE_EN
          sat_acc <= sat_acc | n_one.sat | m0_sat;
`endif
        end
        S_DELTA: begin
          delta_q <= m0_p;
          state   <= S_RATE;
`ifdef BP_SATURATE_EN
          sat_acc <= sat_acc | m0_sat;
`endif
        end
        S_RATE: begin
          dr_q  <= m0_p;
          idx   <= '0;
          state <= S_LOOP;
`ifdef BP_SATURATE_EN
          sat_acc <= sat_acc | m0_sat;
`endif
        end
        S_LOOP: begin
          eo_q <= eo_next;
          wo_q <= wo_next;
`ifdef BP_SATURATE_EN
          sat_acc <= sat_acc | loop_sat;
`endif
          if (idx == LAST) begin
            err_out    <= eo_next;
            weight_out <= wo_next;
            out_valid  <= 1'b1;
            state      <= S_DONE;
`ifdef BP_SATURATE_EN
            sat_flag   <= sat_acc | loop_sat;
`endif
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_backprop_engine.sv
// Self-checking bench for backprop_engine against an integer arithmetic reference model.
module tb_backprop_engine;
  import backprop_pkg::*;

  localparam int N  = 4;
  localparam int WD = 16;
  localparam int FR = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_valid1 = 1'b0;
  logic out_ready = 1'b0, out_ready1 = 1'b0;
  logic in_ready, in_ready1, out_valid, out_valid1, busy, busy1;
  logic signed [WD-1:0] axon = '0, err_in = '0, ratio = '0;
  logic [N-1:0][WD-1:0] prev = '0, weight = '0, err_out, weight_out;
  logic [0:0][WD-1:0]   prev1 = '0, weight1 = '0, err_out1, weight_out1;
`ifdef BP_SATURATE_EN
  logic sat_flag, sat_flag1;
`endif

  int errors = 0;
  int checks = 0;

  int s_prev[N];
  int s_w[N];
  int m_eo[N];
  int m_wo[N];
  bit m_sat;

  always #5 clk = ~clk;

  backprop_engine #(.N_INPUTS(N), .WIDTH(WD), .FRAC(FR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .axon(axon), .err_in(err_in), .ratio(ratio), .prev(prev), .weight(weight),
    .out_valid(out_valid), .out_ready(out_ready), .err_out(err_out),
    .weight_out(weight_out), .busy(busy)
`ifdef BP_SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );

  backprop_engine #(.N_INPUTS(1), .WIDTH(WD), .FRAC(FR)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .axon(axon), .err_in(err_in), .ratio(ratio), .prev(prev1), .weight(weight1),
    .out_valid(out_valid1), .out_ready(out_ready1), .err_out(err_out1),
    .weight_out(weight_out1), .busy(busy1)
`ifdef BP_SATURATE_EN
    , .sat_flag(sat_flag1)
`endif
  );

  // ---------------- reference model ----------------
  function automatic int nrw(longint x);
    longint y;
`ifdef BP_SATURATE_EN
    if (x > 32767) begin m_sat = 1'b1; return 32767; end
    if (x < -32768) begin m_sat = 1'b1; return -32768; end
    return int'(x);
`else
    y = x & 64'hFFFF;
    if (y >= 32768) y = y - 65536;
    return int'(y);
`endif
  endfunction

  function automatic int mulm(int x, int y);
    longint p;
    p = longint'(x) * longint'(y);
    return nrw(p >>> FR);
  endfunction

  task automatic model(input int a, input int e, input int r, input int n);
    int sig, delta, dr;
    m_sat = 1'b0;
    sig   = mulm(nrw(ONE - a), a);
    delta = mulm(sig, e);
    dr    = mulm(delta, r);
    for (int i = 0; i < n; i++) begin
      m_eo[i] = mulm(delta, s_w[i]);
      m_wo[i] = nrw(longint'(s_w[i]) + longint'(mulm(dr, s_prev[i])));
    end
  endtask

  function automatic int rnd16();
    logic [15:0] v;
    v = 16'($urandom);
    return int'($signed(v));
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic issue0(input int a, input int e, input int r);
    @(negedge clk);
    axon = WD'(a); err_in = WD'(e); ratio = WD'(r);
    for (int i = 0; i < N; i++) begin
      prev[i] = WD'(s_prev[i]);
      weight[i] = WD'(s_w[i]);
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    axon = WD'($urandom); err_in = WD'($urandom); ratio = WD'($urandom);
    for (int i = 0; i < N; i++) begin
      prev[i] = WD'($urandom);
      weight[i] = WD'($urandom);
    end
  endtask

  task automatic wait_valid0(output int lat, output bit to);
    lat = 0; to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin to = 1'b0; break; end
    end
  endtask

  task automatic release0();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || err_out !== '0 || weight_out !== '0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b busy=%b err_out=%h weight_out=%h, need 0", out_valid, busy, err_out, weight_out);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b need 1/1", in_ready, in_ready1);
    end
  endtask

  task automatic test_basic();
    int lat; bit to;
    for (int i = 0; i < N; i++) begin s_w[i] = rnd16(); s_prev[i] = rnd16(); end
    s_w[0] = 2048; s_prev[0] = 4096;
    model(2048, 4096, 2048, N);
    issue0(2048, 4096, 2048);
    wait_valid0(lat, to);
    checks++;
    if (to || lat != N + 3) begin errors++; $display("FAIL basic_latency: got %0d need %0d (timeout=%b)", lat, N + 3, to); end
    checks++;
    if (err_out[0] !== 16'sd512 || weight_out[0] !== 16'sd2560) begin
      errors++;
      $display("FAIL basic_lane0: err_out=%0d weight_out=%0d need 512/2560", $signed(err_out[0]), $signed(weight_out[0]));
    end
    for (int i = 1; i < N; i++) begin
      checks++;
      if (err_out[i] !== WD'(m_eo[i]) || weight_out[i] !== WD'(m_wo[i])) begin
        errors++;
        $display("FAIL basic_lane%0d: got %0d/%0d need %0d/%0d", i, $signed(err_out[i]), $signed(weight_out[i]), m_eo[i], m_wo[i]);
      end
    end
    release0();
  endtask

  task automatic test_negative();
    int lat; bit to;
    for (int i = 0; i < N; i++) begin s_w[i] = 4096; s_prev[i] = 4096; end
    issue0(2048, -4096, 4096);
    wait_valid0(lat, to);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (to || err_out[i] !== -16'sd1024 || weight_out[i] !== 16'sd3072) begin
        errors++;
        $display("FAIL negative_lane%0d: got %0d/%0d need -1024/3072", i, $signed(err_out[i]), $signed(weight_out[i]));
      end
    end
    release0();
  endtask

  task automatic test_saturation();
    int lat; bit to; int exp_w;
`ifdef BP_SATURATE_EN
    exp_w = 32767;
`else
    exp_w = -16388;
`endif
    for (int i = 0; i < N; i++) begin s_w[i] = 0; s_prev[i] = 0; end
    s_w[0] = 16384; s_prev[0] = 16384;
    issue0(2048, 32767, 4096);
    wait_valid0(lat, to);
    checks++;
    if (to || weight_out[0] !== WD'(exp_w)) begin
      errors++;
      $display("FAIL saturation_weight: got %0d need %0d", $signed(weight_out[0]), exp_w);
    end
`ifdef BP_SATURATE_EN
    checks++;
    if (sat_flag !== 1'b1) begin errors++; $display("FAIL saturation_flag: got %b need 1", sat_flag); end
`endif
    release0();
  endtask

  task automatic test_random();
    int lat; bit to; int a, e, r;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < N; i++) begin s_w[i] = rnd16(); s_prev[i] = rnd16(); end
      a = (t % 2 == 0) ? int'($urandom_range(0, 4096)) : rnd16();
      e = rnd16(); r = rnd16();
      model(a, e, r, N);
      issue0(a, e, r);
      wait_valid0(lat, to);
      checks++;
      if (to || lat != N + 3) begin errors++; $display("FAIL random%0d_latency: got %0d need %0d", t, lat, N + 3); end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (err_out[i] !== WD'(m_eo[i]) || weight_out[i] !== WD'(m_wo[i])) begin
          errors++;
          $display("FAIL random%0d_lane%0d: got %0d/%0d need %0d/%0d", t, i, $signed(err_out[i]), $signed(weight_out[i]), m_eo[i], m_wo[i]);
        end
      end
`ifdef BP_SATURATE_EN
      checks++;
      if (sat_flag !== m_sat) begin errors++; $display("FAIL random%0d_sat: got %b need %b", t, sat_flag, m_sat); end
`endif
      release0();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    logic [N-1:0][WD-1:0] snap_e, snap_w;
    for (int i = 0; i < N; i++) begin s_w[i] = rnd16(); s_prev[i] = rnd16(); end
    model(2048, 4096, 2048, N);
    issue0(2048, 4096, 2048);
    wait_valid0(lat, to);
    snap_e = err_out; snap_w = weight_out;
    axon = 16'sd100; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (to || out_valid !== 1'b1 || in_ready !== 1'b0 || err_out !== snap_e || weight_out !== snap_w) begin
        errors++;
        $display("FAIL backpressure_hold%0d: out_valid=%b in_ready=%b stable=%b", c, out_valid, in_ready, (err_out === snap_e && weight_out === snap_w));
      end
    end
    checks++;
    if (weight_out[0] !== WD'(m_wo[0])) begin
      errors++;
      $display("FAIL backpressure_value: got %0d need %0d", $signed(weight_out[0]), m_wo[0]);
    end
    in_valid = 1'b0;
    release0();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_not_queued: busy=%b in_ready=%b out_valid=%b need 0/1/0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit to;
    for (int i = 0; i < N; i++) begin s_w[i] = rnd16(); s_prev[i] = rnd16(); end
    s_w[0] = 2048; s_prev[0] = 4096;
    issue0(2048, 4096, 2048);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || weight_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_cleared: out_valid=%b busy=%b weight_out=%h need 0", out_valid, busy, weight_out);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
    end
    issue0(2048, 4096, 2048);
    wait_valid0(lat, to);
    checks++;
    if (to || lat != N + 3 || err_out[0] !== 16'sd512 || weight_out[0] !== 16'sd2560) begin
      errors++;
      $display("FAIL reset_mid_rerun: lat=%0d err_out=%0d weight_out=%0d need %0d/512/2560", lat, $signed(err_out[0]), $signed(weight_out[0]), N + 3);
    end
    release0();
  endtask

  task automatic test_single_input();
    int lat; bit to; int wv;
    int avals[2] = '{0, 4096};
    for (int t = 0; t < 2; t++) begin
      wv = rnd16();
      @(negedge clk);
      axon = WD'(avals[t]); err_in = WD'(rnd16()); ratio = WD'(rnd16());
      weight1[0] = WD'(wv); prev1[0] = WD'(rnd16());
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      weight1[0] = WD'($urandom);
      lat = 0; to = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        lat++;
        if (out_valid1) begin to = 1'b0; break; end
      end
      checks++;
      if (to || lat != 4 || err_out1[0] !== '0 || weight_out1[0] !== WD'(wv)) begin
        errors++;
        $display("FAIL single_a%0d: lat=%0d err_out=%0d weight_out=%0d need 4/0/%0d", avals[t], lat, $signed(err_out1[0]), $signed(weight_out1[0]), wv);
      end
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int rise[2]; int nr; bit last_ov;
    for (int i = 0; i < N; i++) begin s_w[i] = rnd16(); s_prev[i] = rnd16(); end
    model(1000, 3000, 1500, N);
    @(negedge clk);
    axon = WD'(1000); err_in = WD'(3000); ratio = WD'(1500);
    for (int i = 0; i < N; i++) begin prev[i] = WD'(s_prev[i]); weight[i] = WD'(s_w[i]); end
    in_valid = 1'b1; out_ready = 1'b1;
    nr = 0; last_ov = 1'b0; rise[0] = 0; rise[1] = 0;
    for (int c = 1; c <= 60 && nr < 2; c++) begin
      @(posedge clk); #1;
      if (out_valid && !last_ov) begin
        rise[nr] = c;
        nr++;
        checks++;
        if (err_out[N-1] !== WD'(m_eo[N-1]) || weight_out[N-1] !== WD'(m_wo[N-1])) begin
          errors++;
          $display("FAIL back_to_back_value%0d: got %0d/%0d need %0d/%0d", nr, $signed(err_out[N-1]), $signed(weight_out[N-1]), m_eo[N-1], m_wo[N-1]);
        end
      end
      last_ov = out_valid;
    end
    in_valid = 1'b0;
    checks++;
    if (nr != 2 || rise[1] - rise[0] != N + 5) begin
      errors++;
      $display("FAIL back_to_back_interval: got %0d (rises=%0d) need %0d", rise[1] - rise[0], nr, N + 5);
    end
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_single_input();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout need completion");
    $fatal(1, "watchdog");
  end

endmodule
